alu_dispatch_scheduler: RTL and testbench
=========================================

Name: alu_dispatch_scheduler

Overview:
- Shares a pool of NUM_ALU alu_controller instances among a single issue stream.
- Picks a free ALU round-robin and drives its in_alu_select and in_alu_select_flopped.
- Records which wavefront (wfid) occupies each ALU and returns one completion record per instruction as each ALU's out_instr_done arrives.
- Sits between the issue stage and the SIMD/SIMF ALU controllers.

Parameters:
- NUM_ALU, 4: number of ALU controllers scheduled (2..8).
- ALU_IDX_W, 2: width of an ALU index; must satisfy 2**ALU_IDX_W >= NUM_ALU.
- WFID_W, 6: wavefront id width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- in_issue_valid  in  1  issue stage presents an instruction.
- in_issue_wfid  in  WFID_W  wavefront id of the presented instruction.
- out_issue_ready  out  1  at least one ALU is eligible this cycle.
- in_alu_ready  in  NUM_ALU  per-ALU out_alu_ready from the controllers.
- in_instr_done  in  NUM_ALU  per-ALU out_instr_done pulse.
- out_alu_select  out  NUM_ALU  one-hot grant, combinational, valid in the handshake cycle.
- out_alu_select_flopped  out  NUM_ALU  out_alu_select registered by one cycle.
- out_done_valid  out  1  completion record valid, registered.
- out_done_wfid  out  WFID_W  wfid of the completed instruction.
- out_done_alu  out  ALU_IDX_W  index of the ALU that completed.
- out_busy_count  out  ALU_IDX_W+1  number of ALUs currently busy.

Behaviour:
- State:
  - busy[NUM_ALU]: ALU holds an unreported instruction.
  - pend[NUM_ALU]: done received, not yet reported.
  - wfid_tab[NUM_ALU]: wfid per ALU.
  - rr_ptr[ALU_IDX_W]: round-robin start point.
- Reset (rst=0, asynchronous): busy, pend, rr_ptr, out_alu_select_flopped, out_done_valid, out_done_wfid, out_done_alu and out_busy_count all go to 0. wfid_tab is cleared to 0.
- Eligibility: eligible[i] = ~busy[i] & in_alu_ready[i], using the registered busy only.
- out_issue_ready = |eligible.
- Handshake: fire = in_issue_valid & out_issue_ready.
- Grant selection: on fire, grant is the first eligible index searching rr_ptr, rr_ptr+1, ... modulo NUM_ALU.
  - out_alu_select = onehot(grant) when fire, else 0.
  - No select bit is asserted without fire.
- On the clock edge after fire:
  - busy[grant] <= 1.
  - wfid_tab[grant] <= in_issue_wfid.
  - rr_ptr <= (grant+1) mod NUM_ALU.
  - out_alu_select_flopped <= out_alu_select, so it is high for exactly one cycle, one cycle after select.
- Done capture: in_instr_done[i] & busy[i] sets pend[i]. Several ALUs may finish in the same cycle; each is captured.
- Done report (one per cycle):
  - If any pend bit is set, k = lowest-index set bit.
  - Next edge: out_done_valid <= 1, out_done_wfid <= wfid_tab[k], out_done_alu <= k; pend[k] and busy[k] clear.
  - Otherwise out_done_valid <= 0.
  - The report latency is 1 cycle after capture when there is no contention.
- Busy lifetime: an ALU stays busy until its record is reported, so it is never re-granted before its wfid has been returned.
  - A freed ALU becomes eligible the cycle after its report.
- in_instr_done on a non-busy ALU is ignored.
- in_instr_done while pend[i] is already set is ignored; the ALU protocol guarantees one done per start.
- Same-cycle events:
  - Dispatch to ALU a and report of ALU b (a != b) both proceed.
  - Dispatch to ALU a and a done from ALU a cannot coincide, since a busy ALU is never eligible.
- out_busy_count is registered and equals the population count of next-state busy.
- in_alu_ready low on a non-busy ALU only masks eligibility. It does not alter busy.
- No flow control on out_done_valid: the consumer must accept one record per cycle.

Optional Feature:
- Macro: ALU_SCHED_ERR_EN.
- When defined:
  - Adds output out_sched_err (1 bit, reset 0, sticky until reset).
  - Sets on in_instr_done[i] while ~busy[i] or pend[i] (spurious or duplicate done).
  - Sets on fire with in_issue_valid while out_issue_ready=0 being impossible by design; the only error sources are these done conditions.
  - Adds output out_err_alu (ALU_IDX_W), capturing the lowest offending index on the first error only.
- When undefined: neither port exists and spurious dones are silently ignored.

Test Plan:
- Reset, then in_alu_ready=4'b1111 and four back-to-back valid issues with wfid 1,2,3,4 -> out_alu_select 0001, 0010, 0100, 1000 on consecutive cycles; out_issue_ready drops to 0 on the fifth cycle; out_busy_count reaches 4.
- All four busy, then in_instr_done=4'b1010 in one cycle -> out_done_valid for 2 consecutive cycles: (alu=1, wfid=2) then (alu=3, wfid=4); out_busy_count 4 -> 3 -> 2.
- Round-robin: after a grant to ALU2, free ALUs {0,3} -> next grant goes to ALU3, not ALU0.
- in_alu_ready=4'b0100 with all non-busy -> only ALU2 is granted; with in_alu_ready=0, out_issue_ready=0 and out_alu_select=0 even while in_issue_valid=1.
- Done from ALU0 is reported in cycle T while a new issue arrives in T -> ALU0 is not granted in T; ALU0 is granted in T+1 if it is the next in round-robin order.
- Assert rst=0 asynchronously mid-operation with 3 ALUs busy and 2 pend bits set -> all outputs are 0 immediately; after release, no stale done records appear. With ALU_SCHED_ERR_EN defined, a done on an idle ALU2 -> out_sched_err=1 and out_err_alu=2.

Source files
------------

// File: rtl/alu_dispatch_scheduler.sv
// Round-robin dispatch of one issue stream onto NUM_ALU ALU controllers with in-order-by-index completion reporting.
// Optional macro ALU_SCHED_ERR_EN adds a sticky spurious/duplicate-done error flag and the offending ALU index.
module alu_dispatch_scheduler #(
  parameter int NUM_ALU   = 4,
  parameter int ALU_IDX_W = 2,
  parameter int WFID_W    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_issue_valid,
  input  logic [WFID_W-1:0]    in_issue_wfid,
  output logic                 out_issue_ready,
  input  logic [NUM_ALU-1:0]   in_alu_ready,
  input  logic [NUM_ALU-1:0]   in_instr_done,
  output logic [NUM_ALU-1:0]   out_alu_select,
  output logic [NUM_ALU-1:0]   out_alu_select_flopped,
  output logic                 out_done_valid,
  output logic [WFID_W-1:0]    out_done_wfid,
  output logic [ALU_IDX_W-1:0] out_done_alu,
`ifdef ALU_SCHED_ERR_EN
  output logic                 out_sched_err,
  output logic [ALU_IDX_W-1:0] out_err_alu,
`endif
  output logic [ALU_IDX_W:0]   out_busy_count
);

  logic [NUM_ALU-1:0]   busy_q, busy_d;
  logic [NUM_ALU-1:0]   pend_q, pend_d;
  logic [WFID_W-1:0]    wfid_tab_q [NUM_ALU];
  logic [ALU_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_ALU-1:0]   sel_flop_q;
  logic                 done_valid_q;
  logic [WFID_W-1:0]    done_wfid_q;
  logic [ALU_IDX_W-1:0] done_alu_q;
  logic [ALU_IDX_W:0]   busy_cnt_q, busy_cnt_d;

  logic [NUM_ALU-1:0]   eligible;
  logic                 fire;
  logic                 grant_found;
  logic [ALU_IDX_W-1:0] grant_idx;
  logic [NUM_ALU-1:0]   sel;
  logic                 rep_valid;
  logic [ALU_IDX_W-1:0] rep_idx;
  logic [NUM_ALU-1:0]   rep_onehot;
  logic [NUM_ALU-1:0]   pend_set;
  int                   cand;
  int                   nxt;

  // Issue handshake: an instruction transfers in any cycle where in_issue_valid and
  // out_issue_ready are both high; out_alu_select is the grant for exactly that cycle.
  always_comb begin
    eligible    = ~busy_q & in_alu_ready;
    fire        = in_issue_valid & (|eligible);
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int off = 0; off < NUM_ALU; off++) begin
      cand = int'(rr_ptr_q) + off;
      if (cand >= NUM_ALU) cand = cand - NUM_ALU;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ALU_IDX_W'(cand);
      end
    end
    sel = '0;
    if (fire) sel[grant_idx] = 1'b1;
    nxt = int'(grant_idx) + 1;
    if (nxt >= NUM_ALU) nxt = 0;
    rr_ptr_d = fire ? ALU_IDX_W'(nxt) : rr_ptr_q;
  end

  // Lowest pending index wins the single report slot each cycle.
  always_comb begin
    rep_valid  = |pend_q;
    rep_idx    = '0;
    rep_onehot = '0;
    for (int i = NUM_ALU - 1; i >= 0; i--) begin
      if (pend_q[i]) rep_idx = ALU_IDX_W'(i);
    end
    if (rep_valid) rep_onehot[rep_idx] = 1'b1;
    pend_set   = in_instr_done & busy_q & ~pend_q;
    busy_d     = (busy_q | sel) & ~rep_onehot;
    pend_d     = (pend_q | pend_set) & ~rep_onehot;
    busy_cnt_d = '0;
    for (int i = 0; i < NUM_ALU; i++) begin
      busy_cnt_d = busy_cnt_d + (ALU_IDX_W + 1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q       <= '0;
      pend_q       <= '0;
      rr_ptr_q     <= '0;
      sel_flop_q   <= '0;
      done_valid_q <= 1'b0;
      done_wfid_q  <= '0;
      done_alu_q   <= '0;
      busy_cnt_q   <= '0;
      for (int i = 0; i < NUM_ALU; i++) wfid_tab_q[i] <= '0;
    end else begin
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      rr_ptr_q     <= rr_ptr_d;
      sel_flop_q   <= sel;
      busy_cnt_q   <= busy_cnt_d;
      done_valid_q <= rep_valid;
      if (fire) wfid_tab_q[grant_idx] <= in_issue_wfid;
      if (rep_valid) begin
        done_wfid_q <= wfid_tab_q[rep_idx];
        done_alu_q  <= rep_idx;
      end
    end
  end

`ifdef ALU_SCHED_ERR_EN
  logic [NUM_ALU-1:0]   err_bits;
  logic [ALU_IDX_W-1:0] err_idx;
  logic                 err_q;
  logic [ALU_IDX_W-1:0] err_alu_q;

  always_comb begin
    err_bits = in_instr_done & (~busy_q | pend_q);
    err_idx  = '0;
    for (int i = NUM_ALU - 1; i >= 0; i--) begin
      if (err_bits[i]) err_idx = ALU_IDX_W'(i);
    end
  end

  // Only the first offence is recorded; the flag stays set until reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q     <= 1'b0;
      err_alu_q <= '0;
    end else if (!err_q && (|err_bits)) begin
      err_q     <= 1'b1;
      err_alu_q <= err_idx;
    end
  end

  assign out_sched_err = err_q;
  assign out_err_alu   = err_alu_q;
`endif

  assign out_issue_ready        = |eligible;
  assign out_alu_select         = sel;
  assign out_alu_select_flopped = sel_flop_q;
  assign out_done_valid         = done_valid_q;
  assign out_done_wfid          = done_wfid_q;
  assign out_done_alu           = done_alu_q;
  assign out_busy_count         = busy_cnt_q;

endmodule

// File: tb/tb_alu_dispatch_scheduler.sv
// Directed bench for alu_dispatch_scheduler; completion records are checked against an expected queue.
module tb_alu_dispatch_scheduler;
  localparam int NUM_ALU   = 4;
  localparam int ALU_IDX_W = 2;
  localparam int WFID_W    = 6;
  localparam int RW        = ALU_IDX_W + WFID_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_issue_valid = 1'b0;
  logic [WFID_W-1:0]    in_issue_wfid = '0;
  logic                 out_issue_ready;
  logic [NUM_ALU-1:0]   in_alu_ready = '0;
  logic [NUM_ALU-1:0]   in_instr_done = '0;
  logic [NUM_ALU-1:0]   out_alu_select;
  logic [NUM_ALU-1:0]   out_alu_select_flopped;
  logic                 out_done_valid;
  logic [WFID_W-1:0]    out_done_wfid;
  logic [ALU_IDX_W-1:0] out_done_alu;
  logic [ALU_IDX_W:0]   out_busy_count;
`ifdef ALU_SCHED_ERR_EN
  logic                 out_sched_err;
  logic [ALU_IDX_W-1:0] out_err_alu;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0]     exp_q [$];
  logic [WFID_W-1:0] model_wfid [NUM_ALU];

  alu_dispatch_scheduler #(
    .NUM_ALU(NUM_ALU), .ALU_IDX_W(ALU_IDX_W), .WFID_W(WFID_W)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .in_issue_valid         (in_issue_valid),
    .in_issue_wfid          (in_issue_wfid),
    .out_issue_ready        (out_issue_ready),
    .in_alu_ready           (in_alu_ready),
    .in_instr_done          (in_instr_done),
    .out_alu_select         (out_alu_select),
    .out_alu_select_flopped (out_alu_select_flopped),
    .out_done_valid         (out_done_valid),
    .out_done_wfid          (out_done_wfid),
    .out_done_alu           (out_done_alu),
`ifdef ALU_SCHED_ERR_EN
    .out_sched_err          (out_sched_err),
    .out_err_alu            (out_err_alu),
`endif
    .out_busy_count         (out_busy_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven from here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_done(input int alu);
    exp_q.push_back({ALU_IDX_W'(alu), model_wfid[alu]});
  endtask

  // Scoreboard: every reported record must match the oldest expected one.
  always @(negedge clk) begin
    logic [RW-1:0] exp_rec;
    if (out_done_valid) begin
      if (exp_q.size() == 0) begin
        check("done_unexpected", {31'b0, out_done_valid}, 32'd0);
      end else begin
        exp_rec = exp_q.pop_front();
        check("done_rec", {24'b0, out_done_alu, out_done_wfid}, {24'b0, exp_rec});
      end
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready", {31'b0, out_issue_ready}, 0);
    check("rst_sel", {28'b0, out_alu_select}, 0);
    check("rst_flop", {28'b0, out_alu_select_flopped}, 0);
    check("rst_done_valid", {31'b0, out_done_valid}, 0);
    check("rst_busy_count", {29'b0, out_busy_count}, 0);
`ifdef ALU_SCHED_ERR_EN
    check("rst_err", {31'b0, out_sched_err}, 0);
`endif
    @(negedge clk) rst = 1'b1;

    // Four back-to-back issues fill the pool in round-robin order.
    step();
    in_alu_ready = 4'b1111; in_issue_valid = 1'b1; in_issue_wfid = 6'd1;
    #1;
    check("fill_ready", {31'b0, out_issue_ready}, 1);
    check("fill_sel0", {28'b0, out_alu_select}, 32'b0001);
    model_wfid[0] = 6'd1;
    for (int i = 1; i < 4; i++) begin
      step();
      in_issue_wfid = WFID_W'(i + 1);
      #1;
      check("fill_sel", {28'b0, out_alu_select}, 32'd1 << i);
      check("fill_flop", {28'b0, out_alu_select_flopped}, 32'd1 << (i - 1));
      check("fill_count", {29'b0, out_busy_count}, i);
      model_wfid[i] = WFID_W'(i + 1);
    end
    step();
    in_issue_wfid = 6'd5;
    #1;
    check("full_ready", {31'b0, out_issue_ready}, 0);
    check("full_sel", {28'b0, out_alu_select}, 0);
    check("full_flop", {28'b0, out_alu_select_flopped}, 32'b1000);
    check("full_count", {29'b0, out_busy_count}, 4);
    in_issue_valid = 1'b0;

    // Two dones in one cycle are reported on consecutive cycles, lowest index first.
    step();
    in_instr_done = 4'b1010; push_done(1); push_done(3);
    #1; check("d1010_count_a", {29'b0, out_busy_count}, 4);
    step(); in_instr_done = '0;
    #1; check("d1010_nodone", {31'b0, out_done_valid}, 0);
    check("d1010_count_b", {29'b0, out_busy_count}, 4);
    step(); #1; check("d1010_valid1", {31'b0, out_done_valid}, 1);
    check("d1010_count_c", {29'b0, out_busy_count}, 3);
    step(); #1; check("d1010_valid2", {31'b0, out_done_valid}, 1);
    check("d1010_count_d", {29'b0, out_busy_count}, 2);
    step(); #1; check("d1010_idle", {31'b0, out_done_valid}, 0);

    // Drain the rest so every ALU is free again.
    in_instr_done = 4'b0101; push_done(0); push_done(2);
    step(); in_instr_done = '0;
    step(); step();
    #1; check("drain_count", {29'b0, out_busy_count}, 0);

    // Ready mask restricts the grant; no ready means no select even with valid.
    step();
    in_alu_ready = 4'b0100; in_issue_valid = 1'b1; in_issue_wfid = 6'd10;
    #1; check("mask_sel", {28'b0, out_alu_select}, 32'b0100);
    model_wfid[2] = 6'd10;
    step(); in_alu_ready = 4'b0000;
    #1; check("noready_ready", {31'b0, out_issue_ready}, 0);
    check("noready_sel", {28'b0, out_alu_select}, 0);
    check("noready_count", {29'b0, out_busy_count}, 1);

    // After a grant to ALU2 with {0,3} free, ALU3 wins.
    step(); in_alu_ready = 4'b1001; in_issue_wfid = 6'd11;
    #1; check("rr_after2", {28'b0, out_alu_select}, 32'b1000);
    model_wfid[3] = 6'd11;
    step(); in_issue_valid = 1'b0; in_alu_ready = 4'b1111;
    #1; check("rr_count", {29'b0, out_busy_count}, 2);
    step(); in_issue_valid = 1'b1; in_issue_wfid = 6'd12;
    #1; check("rr_wrap0", {28'b0, out_alu_select}, 32'b0001);
    model_wfid[0] = 6'd12;
    step(); in_issue_wfid = 6'd13;
    #1; check("rr_next1", {28'b0, out_alu_select}, 32'b0010);
    model_wfid[1] = 6'd13;

    // ALU0 reporting in cycle T is not grantable until T+1.
    step(); in_issue_valid = 1'b0; in_instr_done = 4'b0001; push_done(0);
    #1; check("t_count_full", {29'b0, out_busy_count}, 4);
    step(); in_instr_done = '0; in_issue_valid = 1'b1; in_issue_wfid = 6'd14;
    #1; check("t_ready", {31'b0, out_issue_ready}, 0);
    check("t_sel", {28'b0, out_alu_select}, 0);
    step();
    #1; check("t1_sel", {28'b0, out_alu_select}, 32'b0001);
    check("t1_done_valid", {31'b0, out_done_valid}, 1);
    check("t1_count", {29'b0, out_busy_count}, 3);
    model_wfid[0] = 6'd14;
    step(); in_issue_valid = 1'b0;
    #1; check("t2_count", {29'b0, out_busy_count}, 4);

    // Asynchronous reset with three busy and two pending.
    in_instr_done = 4'b0010; push_done(1);
    step(); in_instr_done = '0;
    step(); step();
    #1; check("pre_rst_count", {29'b0, out_busy_count}, 3);
    in_instr_done = 4'b0101; in_alu_ready = '0;
    step(); in_instr_done = '0;
    #2 rst = 1'b0;
    #1;
    check("arst_ready", {31'b0, out_issue_ready}, 0);
    check("arst_sel", {28'b0, out_alu_select}, 0);
    check("arst_flop", {28'b0, out_alu_select_flopped}, 0);
    check("arst_done_valid", {31'b0, out_done_valid}, 0);
    check("arst_done_wfid", {26'b0, out_done_wfid}, 0);
    check("arst_done_alu", {30'b0, out_done_alu}, 0);
    check("arst_count", {29'b0, out_busy_count}, 0);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(); #1;
      check("post_rst_nodone", {31'b0, out_done_valid}, 0);
      check("post_rst_count", {29'b0, out_busy_count}, 0);
    end
`ifdef ALU_SCHED_ERR_EN
    check("post_rst_err", {31'b0, out_sched_err}, 0);
`endif

    // A done on an idle ALU produces no record.
    in_alu_ready = 4'b1111; in_instr_done = 4'b0100;
    step(); in_instr_done = '0;
    #1; check("spur_count", {29'b0, out_busy_count}, 0);
`ifdef ALU_SCHED_ERR_EN
    check("spur_err", {31'b0, out_sched_err}, 1);
    check("spur_err_alu", {30'b0, out_err_alu}, 2);
`endif
    step(); #1; check("spur_nodone", {31'b0, out_done_valid}, 0);
    step(); #1; check("spur_nodone2", {31'b0, out_done_valid}, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
